// File: rtl/dcache_controller.sv
// dcache_controller: 2-way dcache SRAM initiator with writeback/refill miss FSM; optional DCACHE_PERF_CNT_EN adds hit/miss counters
module dcache_controller #(
  parameter int TAG_W  = 23,
  parameter int IDX_W  = 4,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [IDX_W-1:0]  sram_addr_o,
  output logic [TAG_W+1:0]  sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  input  logic [TAG_W+1:0]  sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  input  logic              sram_hit_i,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);
  localparam int OFF = 32 - TAG_W - IDX_W;
  localparam logic [2:0] IDLE = 3'd0, MISS = 3'd1, WRITEBACK = 3'd2, REFILL = 3'd3, REFILL_WR = 3'd4;
  logic [2:0]        state_q, state_d;
  logic [LINE_W-1:0] victim_q, victim_d, line_q, line_d;
  logic [TAG_W-1:0]  vtag_q, vtag_d;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF+2:0]    sh;
  logic              req, idle, wb, rf, rfw, wr_hit, dirty;
  logic              unused_ok;
  assign tag       = cpu_addr_i[31 -: TAG_W];
  assign idx       = cpu_addr_i[OFF +: IDX_W];
  assign sh        = {cpu_addr_i[OFF-1:2], 5'b0};
  assign unused_ok = ^cpu_addr_i[1:0];
  assign req       = cpu_MemRead_i | cpu_MemWrite_i;
  assign idle      = state_q == IDLE;
  assign wb        = state_q == WRITEBACK;
  assign rf        = state_q == REFILL;
  assign rfw       = state_q == REFILL_WR;
  assign wr_hit    = idle & cpu_MemWrite_i & sram_hit_i;
  assign dirty     = sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W];
  assign cpu_stall_o   = rst_i & req & ~(idle & sram_hit_i);
  assign cpu_data_o    = rst_i ? sram_data_i[sh +: 32] : 32'h0;
  assign sram_addr_o   = idx;
  assign sram_tag_o    = {1'b1, wr_hit, tag};
  assign sram_enable_o = rst_i & (idle & req | rfw);
  assign sram_write_o  = rst_i & (wr_hit | rfw);
  assign sram_data_o   = rfw ? line_q
                             : (sram_data_i & ~({{(LINE_W-32){1'b0}}, 32'hFFFF_FFFF} << sh))
                               | ({{(LINE_W-32){1'b0}}, cpu_data_i} << sh);
  assign mem_enable_o  = wb | rf;
  assign mem_write_o   = wb;
  assign mem_addr_o    = wb ? {vtag_q, idx, {OFF{1'b0}}} : rf ? {tag, idx, {OFF{1'b0}}} : 32'h0;
  assign mem_data_o    = wb ? victim_q : '0;
  // miss sequencing: lookup, optional victim writeback, refill, SRAM line write
  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    vtag_d   = vtag_q;
    line_d   = line_q;
    case (state_q)
      IDLE:      state_d = req & ~sram_hit_i ? MISS : IDLE;
      MISS: begin
        state_d  = dirty ? WRITEBACK : REFILL;
        victim_d = dirty ? sram_data_i : victim_q;
        vtag_d   = dirty ? sram_tag_i[TAG_W-1:0] : vtag_q;
      end
      WRITEBACK: state_d = mem_ack_i ? REFILL : WRITEBACK;
      REFILL: begin
        state_d = mem_ack_i ? REFILL_WR : REFILL;
        line_d  = mem_ack_i ? mem_data_i : line_q;
      end
      default:   state_d = IDLE;
    endcase
  end
  // state and line buffers; reset abandons any memory transaction in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      victim_q <= '0;
      vtag_q   <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      vtag_q   <= vtag_d;
      line_q   <= line_d;
    end
  end
`ifdef DCACHE_PERF_CNT_EN
  logic        relook_q;
  logic [31:0] hit_q, miss_q;
  assign hit_cnt_o  = hit_q;
  assign miss_cnt_o = miss_q;
  // saturating hit/miss counters; the re-lookup hit after a refill is not a new hit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      relook_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      relook_q <= rfw;
      hit_q    <= idle & req & sram_hit_i & ~relook_q & ~&hit_q ? hit_q + 32'd1 : hit_q;
      miss_q   <= idle & req & ~sram_hit_i & ~&miss_q ? miss_q + 32'd1 : miss_q;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: scoreboard bench with 2-way SRAM and latency memory models
module tb_dcache_controller;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o, mem_addr_o;
  logic         cpu_MemRead_i, cpu_MemWrite_i, cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i, mem_data_o, mem_data_i;
  logic         sram_enable_o, sram_write_o, sram_hit_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif
  int checks = 0, errors = 0;
  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [31:0] pat(logic [31:0] a);
    return a == 32'h204 ? 32'hDEAD_BEEF : a ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [255:0] dline(logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = pat(base + 32'(k*4));
    return l;
  endfunction
  logic [24:0]  stag [2][16] = '{default: '0};
  logic [255:0] sdat [2][16] = '{default: '0};
  logic         lru [16] = '{default: 1'b0};
  logic         h0, h1, sway;
  int           nwr = 0;
  assign h0 = stag[0][sram_addr_o][24] && stag[0][sram_addr_o][22:0] == cpu_addr_i[31:9];
  assign h1 = stag[1][sram_addr_o][24] && stag[1][sram_addr_o][22:0] == cpu_addr_i[31:9];
  assign sway = h0 ? 1'b0 : h1 ? 1'b1 : lru[sram_addr_o];
  assign sram_hit_i  = h0 | h1;
  assign sram_tag_i  = stag[sway][sram_addr_o];
  assign sram_data_i = sdat[sway][sram_addr_o];
  always @(posedge clk_i) begin
    if (sram_enable_o && sram_write_o) begin
      stag[sway][sram_addr_o] <= sram_tag_o;
      sdat[sway][sram_addr_o] <= sram_data_o;
      nwr <= nwr + 1;
    end
    if (sram_enable_o && (sram_hit_i || sram_write_o)) lru[sram_addr_o] <= ~sway;
  end
  logic [255:0] mem [int unsigned];
  logic [32:0]  mlog [$];
  int           mcnt = 0;
  int           lat = 10;
  always @(negedge clk_i) begin
    mem_ack_i = 1'b0;
    if (!rst_i || !mem_enable_o) mcnt = 0;
    else begin
      mcnt++;
      if (mcnt == lat) begin
        mcnt = 0;
        mem_ack_i = 1'b1;
        mlog.push_back({mem_write_o, mem_addr_o});
        if (mem_write_o) mem[mem_addr_o] = mem_data_o;
        else mem_data_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : dline(mem_addr_o);
      end
    end
  end
  logic [31:0] refm [int unsigned];
  logic [31:0] sbq [$];
  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return refm.exists(a) ? refm[a] : pat(a);
  endfunction
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit done = 0;
    cpu_addr_i = a; cpu_data_i = d; cpu_MemRead_i = rd; cpu_MemWrite_i = wr;
    if (wr) refm[a] = d;
    else sbq.push_back(ref_rd(a));
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (!cpu_stall_o) begin
        done = 1;
        if (!wr) chk("load", cpu_data_o, sbq.pop_front());
      end
    end
    if (!done) chk("timeout", 1'b1, 1'b0);
    @(posedge clk_i); #1;
    cpu_MemRead_i = 0; cpu_MemWrite_i = 0;
  endtask
  initial begin
    int b, w0;
    rst_i = 0; cpu_addr_i = 0; cpu_data_i = 0; cpu_MemRead_i = 0; cpu_MemWrite_i = 0;
    mem_data_i = '0; mem_ack_i = 0;
    #12;
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_sram_en", sram_enable_o, 1'b0);
    chk("rst_mem_en", mem_enable_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 256'h0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    @(posedge clk_i); #1 rst_i = 1;
    b = mlog.size();
    access(1, 0, 32'h204, 0);
    chk("a_req", mlog[b], {1'b0, 32'h200});
    cpu_addr_i = 32'h208; cpu_data_i = 32'h1234_5678; cpu_MemWrite_i = 1; refm[32'h208] = 32'h1234_5678;
    @(negedge clk_i);
    chk("st_stall", cpu_stall_o, 1'b0);
    chk("st_write", sram_write_o, 1'b1);
    chk("st_vd", sram_tag_o[24:23], 2'b11);
    chk("st_word2", sram_data_o[64 +: 32], 32'h1234_5678);
    chk("st_word1", sram_data_o[32 +: 32], 32'hDEAD_BEEF);
    @(posedge clk_i); #1 cpu_MemWrite_i = 0;
    access(1, 0, 32'h600, 0);
    b = mlog.size();
    access(1, 0, 32'h400, 0);
    chk("wb_cnt", 32'(mlog.size() - b), 32'd2);
    chk("wb_req", mlog[b], {1'b1, 32'h200});
    chk("rf_req", mlog[b+1], {1'b0, 32'h400});
    access(1, 0, 32'h208, 0);
    cpu_addr_i = 32'h208; cpu_data_i = 32'hCAFE_F00D; cpu_MemRead_i = 1; cpu_MemWrite_i = 1;
    refm[32'h208] = 32'hCAFE_F00D;
    @(negedge clk_i);
    chk("rw_stall", cpu_stall_o, 1'b0);
    chk("rw_write", sram_write_o, 1'b1);
    @(posedge clk_i); #1 cpu_MemRead_i = 0; cpu_MemWrite_i = 0;
    access(1, 0, 32'h208, 0);
    cpu_addr_i = 32'h800; cpu_MemRead_i = 1;
    for (int i = 0; i < 100 && !(mem_enable_o && !mem_write_o); i++) @(negedge clk_i);
    chk("pre_rst_addr", mem_addr_o, 32'h800);
    w0 = nwr;
    #2 rst_i = 0;
    #1;
    chk("ar_stall", cpu_stall_o, 1'b0);
    chk("ar_mem_en", mem_enable_o, 1'b0);
    chk("ar_mem_wr", mem_write_o, 1'b0);
    chk("ar_sram_en", sram_enable_o, 1'b0);
    chk("ar_sram_wr", sram_write_o, 1'b0);
    chk("ar_mem_addr", mem_addr_o, 32'h0);
    chk("ar_cpu_data", cpu_data_o, 32'h0);
    @(posedge clk_i); #1 cpu_MemRead_i = 0;
    @(posedge clk_i); #1 rst_i = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("ar_nowrite", nwr, w0);
    chk("ar_idle_mem", mem_enable_o, 1'b0);
    #1;
    access(1, 0, 32'h800, 0);
`ifdef DCACHE_PERF_CNT_EN
    rst_i = 0;
    @(posedge clk_i); #1 rst_i = 1;
    access(1, 0, 32'h1020, 0);
    access(1, 0, 32'h1024, 0);
    access(1, 0, 32'h1028, 0);
    access(1, 0, 32'h102C, 0);
    @(negedge clk_i);
    chk("hit_cnt", hit_cnt_o, 32'd3);
    chk("miss_cnt", miss_cnt_o, 32'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
